pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings and the data-memory wait FSM state type.
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One EX-stage operand forwarding select; the younger MEM result beats WB.
module fwd_sel
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic [RW-1:0] rs,
   input  logic [RW-1:0] rd_M,
   input  logic [RW-1:0] rd_W,
   input  logic          regwrite_M,
   input  logic          regwrite_W,
   output logic [1:0]    sel
);

   always_comb begin
      sel = FWD_RF;
      if (regwrite_M && (rd_M != '0) && (rd_M == rs))
         sel = FWD_MEM;
      else if (regwrite_W && (rd_W != '0) && (rd_W == rs))
         sel = FWD_WB;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// data-memory wait/timeout. Optional perf counters via HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NREG    = 32,
   parameter int MEM_TMO = 16,
   localparam int RW     = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] rs1_D,
   input  logic [RW-1:0] rs2_D,
   input  logic          use_rs1_D,
   input  logic          use_rs2_D,
   input  logic [RW-1:0] rd_E,
   input  logic [RW-1:0] rd_M,
   input  logic [RW-1:0] rd_W,
   input  logic [RW-1:0] rs1_E,
   input  logic [RW-1:0] rs2_E,
   input  logic          regwrite_E,
   input  logic          regwrite_M,
   input  logic          regwrite_W,
   input  logic          memread_E,
   input  logic          take_branch_M,
   input  logic          dmem_req,
   input  logic          dmem_ready,
   output logic          stall_F,
   output logic          stall_D,
   output logic          flush_D,
   output logic          flush_E,
   output logic          flush_M,
   output logic          freeze,
   output logic [1:0]    forward_A,
   output logic [1:0]    forward_B,
   output logic          mem_abort,
   output logic          mem_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   flush_cnt,
   output logic [31:0]   wait_cnt
`endif
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

   mem_state_t state;
   logic [7:0] wait_ctr;
   logic       load_use;
   logic       ready_eff;
   logic       abort_cycle;

   // regwrite_E belongs to the stage-control bundle but no hazard here needs it
   logic unused_regwrite_E;
   assign unused_regwrite_E = regwrite_E;

   fwd_sel #(.RW(RW)) u_fwd_a (
      .rs(rs1_E), .rd_M(rd_M), .rd_W(rd_W),
      .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .sel(forward_A)
   );

   fwd_sel #(.RW(RW)) u_fwd_b (
      .rs(rs2_E), .rd_M(rd_M), .rd_W(rd_W),
      .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .sel(forward_B)
   );

   assign load_use = memread_E && (rd_E != '0) &&
                     ((use_rs1_D && (rd_E == rs1_D)) || (use_rs2_D && (rd_E == rs2_D)));

   // A ready strobe only counts while a request is actually outstanding
   assign ready_eff   = dmem_req && dmem_ready;
   assign abort_cycle = (state == ST_WAIT) && !ready_eff && (wait_ctr == TMO_LAST);
   assign freeze      = dmem_req && !dmem_ready && !abort_cycle;
   assign mem_abort   = abort_cycle;

   // A freeze holds every register, so it masks all stalls and bubbles
   assign stall_F = !freeze && load_use && !take_branch_M;
   assign stall_D = stall_F;
   assign flush_D = !freeze && take_branch_M;
   assign flush_E = !freeze && (take_branch_M || load_use);
   assign flush_M = !freeze && take_branch_M;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wait_ctr <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dmem_req && !dmem_ready) begin
                  state    <= ST_WAIT;
                  wait_ctr <= '0;
               end
            end
            ST_WAIT: begin
               if (ready_eff || abort_cycle)
                  state <= ST_IDLE;
               else
                  wait_ctr <= wait_ctr + 8'd1;
               if (abort_cycle)
                  mem_err <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (stall_F)                   stall_cnt <= stall_cnt + 32'd1;
         if (!freeze && take_branch_M)  flush_cnt <= flush_cnt + 32'd1;
         if (freeze)                    wait_cnt  <= wait_cnt + 32'd1;
      end
   end
`endif

endmodule
